// File: rtl/inst_byte_fetcher_pkg.sv
// Shared types for the byte-serial instruction fetch front end.
// Fetch-queue entries pair a returned byte with the address it came from.
package inst_byte_fetcher_pkg;

  typedef logic [7:0]  inst_t;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
  } fq_entry_t;

  localparam int unsigned FQ_DEPTH_DEF = 4;

endpackage

// File: rtl/inst_byte_fetcher_fifo.sv
// First-word-fall-through queue of fetched bytes.
// Head entry is visible combinationally; clear empties it in one cycle.
module fetch_byte_fifo
  import inst_byte_fetcher_pkg::*;
#(
  parameter  int unsigned DEPTH = FQ_DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  fq_entry_t i_wdata,
  input  logic      i_pop,
  input  logic      i_clear,
  output fq_entry_t o_rdata,
  output logic [AW:0] o_count,
  output logic      o_full,
  output logic      o_empty
);

  fq_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset so it can map onto plain register files.
  always_ff @(posedge clk) begin
    if (w_push && !rst && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

  always @(posedge clk) begin
    if (!rst && !i_clear) begin
      assert (!(i_push && o_full));
      assert (!(i_pop && o_empty));
    end
  end

endmodule

// File: rtl/inst_byte_fetcher.sv
// Byte-serial instruction fetcher: credit-limited memory reads,
// an in-flight tracking pipe and a FWFT queue feeding the decoder.
module inst_byte_fetcher
  import inst_byte_fetcher_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       LOAD_LATENCY = 1,
  parameter int unsigned       FQ_DEPTH     = FQ_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        inst,
  output logic [ADDR_W-1:0] pc,
  output logic              valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned IW = $clog2(LOAD_LATENCY + 1);
  localparam int unsigned SW = CW + 1;

  logic [ADDR_W-1:0]       r_fetch_pc;
  logic [LOAD_LATENCY-1:0] r_live;
  logic [ADDR_W-1:0]       r_ppc [LOAD_LATENCY];
  logic                    r_flush_d;

  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [IW-1:0]     w_inflight;
  logic [CW-1:0]     w_count;
  logic [SW-1:0]     w_used;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic              w_full;
  logic              w_empty;
  fq_entry_t         w_wdata;
  fq_entry_t         w_head;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LOAD_LATENCY; i++) begin
      w_inflight = w_inflight + IW'(r_live[i]);
    end
  end

  // Credit counts queued plus in-flight bytes; no pop lookahead.
  assign w_used  = SW'(w_count) + SW'(w_inflight);
  assign w_issue = ~rst & ~flush & (w_used < SW'(FQ_DEPTH));

  assign w_push  = r_live[LOAD_LATENCY-1] & ~flush;
  assign w_wdata = '{inst: mem_rdata, pc: addr_t'(r_ppc[LOAD_LATENCY-1])};

  assign w_valid = ~rst & ~w_empty & ~r_flush_d;
  assign w_pop   = w_valid & ~stall;

  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    unique case (1'b1)
      flush:   w_fetch_pc_nxt = flush_pc;
      w_issue: w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_flush_d  <= 1'b0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_flush_d  <= flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_live <= '0;
    end else begin
      r_live[0] <= w_issue;
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        r_live[i] <= r_live[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_ppc[0] <= r_fetch_pc;
    for (int i = 1; i < LOAD_LATENCY; i++) begin
      r_ppc[i] <= r_ppc[i-1];
    end
  end

  fetch_byte_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_clear (flush),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always @(posedge clk) begin
    if (!rst && !flush) assert (!(w_push && w_full));
  end

  assign mem_en   = w_issue;
  assign mem_addr = r_fetch_pc;
  assign valid    = w_valid;
  assign inst     = rst ? '0 : w_head.inst;
  assign pc       = rst ? '0 : w_head.pc[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_byte_fetcher.sv
// Two fetcher configurations driven by directed and random stimulus,
// checked every cycle against a transaction-level queue model.
module tb_inst_byte_fetcher;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst      [N];
  logic        stall    [N];
  logic        flush    [N];
  logic [31:0] flush_pc [N];
  logic [7:0]  mem_rdata[N];
  logic        mem_en   [N];
  logic [31:0] mem_addr [N];
  logic [7:0]  inst     [N];
  logic [31:0] pc       [N];
  logic        valid    [N];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int dep(input int g);
    return (g == 0) ? 4 : 8;
  endfunction

  function automatic logic [31:0] rpc(input int g);
    return (g == 0) ? 32'h0000_0100 : 32'hFFFF_FFFE;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    inst_byte_fetcher #(
      .ADDR_W       (32),
      .LOAD_LATENCY ((g == 0) ? 1 : 3),
      .FQ_DEPTH     ((g == 0) ? 4 : 8),
      .RESET_PC     ((g == 0) ? 32'h0000_0100 : 32'hFFFF_FFFE)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .mem_en    (mem_en[g]),
      .mem_addr  (mem_addr[g]),
      .mem_rdata (mem_rdata[g]),
      .inst      (inst[g]),
      .pc        (pc[g]),
      .valid     (valid[g]),
      .stall     (stall[g]),
      .flush     (flush[g]),
      .flush_pc  (flush_pc[g])
    );
  end

  task automatic chk(input int g, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, g, cyc, act, exp);
    end
  endtask

  // Memory: byte[a] = a[7:0], returned lat cycles after the request.
  logic [32:0] hist [N][16];

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) hist[g][cyc & 15] = {mem_en[g], mem_addr[g]};
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    for (int g = 0; g < N; g++) begin
      logic [32:0] e;
      e = (cyc >= lat(g)) ? hist[g][(cyc - lat(g)) & 15] : 33'd0;
      mem_rdata[g] = e[32] ? e[7:0] : 8'($urandom);
    end
  end

  // Reference model: pc queue, in-flight list with remaining cycles.
  logic [31:0] mq  [N][16];
  int          mq_n[N] = '{0, 0};
  logic [31:0] ip  [N][8];
  int          ir  [N][8];
  int          in_n[N] = '{0, 0};
  logic [31:0] fpc [N];
  bit          fld [N] = '{0, 0};

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      bit e_en;
      bit e_valid;
      e_en    = !flush[g] && (mq_n[g] + in_n[g] < dep(g));
      e_valid = (mq_n[g] > 0) && !fld[g];
      if (rst[g]) begin
        chk(g, "rst_valid", 32'(valid[g]), 0);
        chk(g, "rst_en", 32'(mem_en[g]), 0);
        chk(g, "rst_inst", 32'(inst[g]), 0);
        chk(g, "rst_pc", pc[g], 0);
        fpc[g]  = rpc(g);
        mq_n[g] = 0;
        in_n[g] = 0;
        fld[g]  = 0;
      end else begin
        chk(g, "valid", 32'(valid[g]), 32'(e_valid));
        chk(g, "mem_en", 32'(mem_en[g]), 32'(e_en));
        if (e_en) chk(g, "mem_addr", mem_addr[g], fpc[g]);
        if (e_valid) begin
          chk(g, "pc", pc[g], mq[g][0]);
          chk(g, "inst", 32'(inst[g]), 32'(mq[g][0][7:0]));
        end
        if (flush[g]) begin
          fpc[g]  = flush_pc[g];
          mq_n[g] = 0;
          in_n[g] = 0;
          fld[g]  = 1;
        end else begin
          if (e_valid && !stall[g]) begin
            for (int i = 1; i < mq_n[g]; i++) mq[g][i-1] = mq[g][i];
            mq_n[g]--;
          end
          for (int i = 0; i < in_n[g]; i++) ir[g][i]--;
          while (in_n[g] > 0 && ir[g][0] == 0) begin
            mq[g][mq_n[g]] = ip[g][0];
            mq_n[g]++;
            for (int i = 1; i < in_n[g]; i++) begin
              ip[g][i-1] = ip[g][i];
              ir[g][i-1] = ir[g][i];
            end
            in_n[g]--;
          end
          if (e_en) begin
            ip[g][in_n[g]] = fpc[g];
            ir[g][in_n[g]] = lat(g);
            in_n[g]++;
            fpc[g] = fpc[g] + 32'd1;
          end
          fld[g] = 0;
        end
      end
    end
  end

  task automatic drive(input int c);
    rst[0]      = 1'b0;
    stall[0]    = (c >= 5 && c <= 9);
    flush[0]    = (c == 14);
    flush_pc[0] = 32'h0000_2000;
    rst[1]      = (c == 32);
    stall[1]    = (c >= 10 && c <= 22);
    flush[1]    = (c == 22);
    flush_pc[1] = 32'h8000_0010;
  endtask

  task automatic lits(input int c);
    case (c)
      0: begin
        chk(0, "c0_en", 32'(mem_en[0]), 1);
        chk(0, "c0_addr", mem_addr[0], 32'h100);
        chk(1, "c0_addr", mem_addr[1], 32'hFFFF_FFFE);
      end
      1: chk(0, "c1_valid", 32'(valid[0]), 0);
      2: begin
        chk(0, "first_valid", 32'(valid[0]), 1);
        chk(0, "first_pc", pc[0], 32'h100);
        chk(0, "first_inst", 32'(inst[0]), 0);
      end
      3: begin
        chk(0, "second_pc", pc[0], 32'h101);
        chk(0, "second_inst", 32'(inst[0]), 32'h01);
        chk(1, "l3_not_yet", 32'(valid[1]), 0);
      end
      4: begin
        chk(1, "wrap_v0", 32'(valid[1]), 1);
        chk(1, "wrap_pc0", pc[1], 32'hFFFF_FFFE);
        chk(1, "wrap_in0", 32'(inst[1]), 32'hFE);
      end
      5: chk(1, "wrap_pc1", pc[1], 32'hFFFF_FFFF);
      6: begin
        chk(1, "wrap_pc2", pc[1], 32'h0);
        chk(1, "wrap_in2", 32'(inst[1]), 32'h00);
      end
      7: chk(1, "wrap_pc3", pc[1], 32'h1);
      9: begin
        chk(0, "stall_hold_pc", pc[0], 32'h103);
        chk(0, "stall_credit", 32'(mem_en[0]), 0);
      end
      11: chk(0, "post_stall_pc", pc[0], 32'h104);
      14: chk(0, "flush_en", 32'(mem_en[0]), 0);
      15: begin
        chk(0, "fl_valid1", 32'(valid[0]), 0);
        chk(0, "fl_en1", 32'(mem_en[0]), 1);
        chk(0, "fl_addr1", mem_addr[0], 32'h2000);
      end
      16: chk(0, "fl_valid2", 32'(valid[0]), 0);
      17: begin
        chk(0, "fl_first_v", 32'(valid[0]), 1);
        chk(0, "fl_first_pc", pc[0], 32'h2000);
        chk(0, "fl_first_in", 32'(inst[0]), 32'h00);
      end
      21: chk(1, "full_credit", 32'(mem_en[1]), 0);
      22: chk(1, "flstall_en", 32'(mem_en[1]), 0);
      26: chk(1, "flstall_v0", 32'(valid[1]), 0);
      27: begin
        chk(1, "flstall_v1", 32'(valid[1]), 1);
        chk(1, "flstall_pc", pc[1], 32'h8000_0010);
        chk(1, "flstall_in", 32'(inst[1]), 32'h10);
      end
      32: begin
        chk(1, "midrst_v", 32'(valid[1]), 0);
        chk(1, "midrst_en", 32'(mem_en[1]), 0);
        chk(1, "midrst_pc", pc[1], 32'h0);
      end
      36: chk(1, "rst_lat_v0", 32'(valid[1]), 0);
      37: begin
        chk(1, "rst_lat_v1", 32'(valid[1]), 1);
        chk(1, "rst_lat_pc", pc[1], 32'hFFFF_FFFE);
      end
      default: ;
    endcase
  endtask

  initial begin
    for (int g = 0; g < N; g++) begin
      rst[g]      = 1'b1;
      stall[g]    = 1'b0;
      flush[g]    = 1'b0;
      flush_pc[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 40; c++) begin
      drive(c);
      @(negedge clk);
      lits(c);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 3000; k++) begin
      for (int g = 0; g < N; g++) begin
        rst[g]   = ($urandom % 200) == 0;
        flush[g] = ($urandom % 30) == 0;
        stall[g] = ($urandom % 4) == 0;
        flush_pc[g] = (($urandom % 4) == 0) ?
                      (32'hFFFF_FFF8 + 32'($urandom % 8)) : 32'($urandom);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
